// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM-cache write-port arbiter.
// Optional statistics block is enabled with DRAM_ARB_STAT_EN.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

package dram_arb_pkg;

  localparam int ARB_ADDR_W = `AXI_ADDR_WIDTH;
  localparam int ARB_DATA_W = `AXI_DATA_WIDTH;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
  } arb_payload_t;

  localparam int REQ_FILL   = 0;
  localparam int REQ_WHIT   = 1;
  localparam int REQ_WALLOC = 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

endpackage

// File: rtl/dram_fill_write_arbiter_rr_pick.sv
// Circular find-first over a valid mask, starting at ptr.
// Purely combinational; shared with the write-back scheduler.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && valid[IW'(j)]) begin
        found          = 1'b1;
        grant[IW'(j)]  = 1'b1;
        idx            = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dram_fill_write_arbiter.sv
// DRAM-cache write-port arbiter: fill priority, RR, aging override.
// Define DRAM_ARB_STAT_EN to add per-requester grant/stall counters.
module dram_fill_write_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = ARB_ADDR_W,
  parameter int DATA_WIDTH   = ARB_DATA_W,
  parameter int WDATA_WIDTH  = ADDR_WIDTH + DATA_WIDTH,
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 4,
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*WDATA_WIDTH-1:0] req_wdata_i,
  output logic                         mem_valid_o,
  input  logic                         mem_ready_i,
  output logic [WDATA_WIDTH-1:0]       mem_wdata_o,
`ifdef DRAM_ARB_STAT_EN
  input  logic [IW-1:0]                stat_sel_i,
  output logic [31:0]                  stat_grant_o,
  output logic [31:0]                  stat_stall_o,
`endif
  output logic [IW-1:0]                mem_src_o
);

  localparam logic [3:0]    LIM      = 4'(STARVE_LIMIT);
  localparam logic [IW-1:0] LAST     = IW'(NUM_REQ - 1);
  localparam logic [IW-1:0] FIRST_RR = IW'(REQ_WHIT);
  localparam logic [IW-1:0] FILL_IDX = IW'(REQ_FILL);

  logic [0:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [3:0]         age [NUM_REQ];
  logic               acc;
  logic               starve_found;
  logic               rr_found;
  logic               win_found;
  logic               grant_en;
  logic [IW-1:0]      starve_idx;
  logic [IW-1:0]      rr_idx;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] rr_mask;
  logic [NUM_REQ-1:0] rr_grant;
  logic [NUM_REQ-1:0] win_oh;
  logic [WDATA_WIDTH-1:0] win_data;

  assign acc         = (state == S_IDLE) || mem_ready_i;
  assign mem_valid_o = (state == S_HOLD);
  assign rr_mask     = req_valid_i & ~NUM_REQ'(1 << REQ_FILL);

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .valid (rr_mask),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // Descending scan so the lowest starved index wins.
  always_comb begin
    starve_found = 1'b0;
    starve_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 1; i--) begin
      if (req_valid_i[i] && age[i] == LIM) begin
        starve_found = 1'b1;
        starve_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    win_idx = rr_idx;
    win_oh  = rr_grant;
    priority case (1'b1)
      starve_found: begin
        win_idx = starve_idx;
        win_oh  = NUM_REQ'(1) << starve_idx;
      end
      req_valid_i[REQ_FILL]: begin
        win_idx = FILL_IDX;
        win_oh  = NUM_REQ'(1 << REQ_FILL);
      end
      default: ;
    endcase
  end

  assign win_found   = starve_found | req_valid_i[REQ_FILL] | rr_found;
  assign grant_en    = rst_n & acc & win_found;
  assign req_ready_o = grant_en ? win_oh : '0;
  assign win_data    = req_wdata_i[win_idx*WDATA_WIDTH +: WDATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mem_wdata_o <= '0;
      mem_src_o   <= '0;
      rr_ptr      <= FIRST_RR;
      for (int i = 0; i < NUM_REQ; i++) age[i] <= '0;
    end else if (grant_en) begin
      state       <= S_HOLD;
      mem_wdata_o <= win_data;
      mem_src_o   <= win_idx;
      if (win_idx != FILL_IDX)
        rr_ptr <= (win_idx == LAST) ? FIRST_RR : win_idx + 1'b1;
      for (int i = 1; i < NUM_REQ; i++) begin
        if (IW'(i) == win_idx || !req_valid_i[i])
          age[i] <= '0;
        else if (age[i] != LIM)
          age[i] <= age[i] + 4'd1;
      end
    end else if (acc) begin
      state <= S_IDLE;
    end
  end

`ifdef DRAM_ARB_STAT_EN
  logic [31:0] stat_grant [NUM_REQ];
  logic [31:0] stat_stall [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_grant[i] <= '0;
        stat_stall[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready_o[i])
          stat_grant[i] <= stat_grant[i] + 32'd1;
        if (req_valid_i[i] && !req_ready_o[i])
          stat_stall[i] <= stat_stall[i] + 32'd1;
      end
    end
  end

  assign stat_grant_o = (int'(stat_sel_i) < NUM_REQ) ?
                        stat_grant[stat_sel_i] : '0;
  assign stat_stall_o = (int'(stat_sel_i) < NUM_REQ) ?
                        stat_stall[stat_sel_i] : '0;
`endif

endmodule

// File: tb/tb_dram_fill_write_arbiter.sv
// Bench for dram_fill_write_arbiter: directed cases plus random traffic
// checked against a cycle-level model of the arbitration rules.
module tb_dram_fill_write_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int W   = AW + DW;
  localparam int N   = 3;
  localparam int LIM = 4;
  localparam int IW  = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_wdata_i;
  logic           mem_valid_o;
  logic           mem_ready_i;
  logic [W-1:0]   mem_wdata_o;
  logic [IW-1:0]  mem_src_o;
`ifdef DRAM_ARB_STAT_EN
  logic [IW-1:0]  stat_sel_i;
  logic [31:0]    stat_grant_o;
  logic [31:0]    stat_stall_o;
`endif

  always #5 clk = ~clk;

  dram_fill_write_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_REQ      (N),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_wdata_i  (req_wdata_i),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .mem_wdata_o  (mem_wdata_o),
`ifdef DRAM_ARB_STAT_EN
    .stat_sel_i   (stat_sel_i),
    .stat_grant_o (stat_grant_o),
    .stat_stall_o (stat_stall_o),
`endif
    .mem_src_o    (mem_src_o)
  );

  int checks = 0;
  int errors = 0;

  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_rr;
  int           m_age [N];
  int           m_gnt [N];
  int           m_stl [N];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Winner from the rules: starved first, then fill, then circular 1..N-1.
  function automatic int pick();
    if (m_valid && !mem_ready_i) return -1;
    if (req_valid_i == '0) return -1;
    for (int i = 1; i < N; i++)
      if (req_valid_i[i] && m_age[i] == LIM) return i;
    if (req_valid_i[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      int i;
      i = 1 + ((m_rr - 1 + k) % (N - 1));
      if (req_valid_i[i]) return i;
    end
    return -1;
  endfunction

  task automatic cycle();
    int w;
    logic [N-1:0] er;
    #1;
    w  = pick();
    er = '0;
    if (rst_n && w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready_o, er);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_src = 0; m_rr = 1;
      for (int i = 0; i < N; i++) begin
        m_age[i] = 0; m_gnt[i] = 0; m_stl[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (er[i]) m_gnt[i]++;
        else if (req_valid_i[i]) m_stl[i]++;
      end
      if (w >= 0) begin
        for (int i = 1; i < N; i++)
          m_age[i] = (i == w || !req_valid_i[i]) ? 0 :
                     (m_age[i] + 1 > LIM ? LIM : m_age[i] + 1);
        if (w != 0) m_rr = (w == N - 1) ? 1 : w + 1;
        m_valid = 1;
        m_data  = req_wdata_i[w*W +: W];
        m_src   = w;
      end else if (mem_ready_i) begin
        m_valid = 0;
      end
    end
    @(negedge clk);
    chk("mem_valid", mem_valid_o, m_valid);
    chk("mem_src", mem_src_o, m_src);
    chk("mem_wdata", mem_wdata_o, m_data);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid_i = '0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0]  hd;
    logic [IW-1:0] hs;
    rst_n       = 1'b0;
    req_valid_i = '0;
    req_wdata_i = '0;
    mem_ready_i = 1'b0;
`ifdef DRAM_ARB_STAT_EN
    stat_sel_i  = '0;
`endif
    do_reset();
    chk("rst_valid", mem_valid_o, 1'b0);
    chk("rst_src", mem_src_o, 2'd0);
    chk("rst_wdata", mem_wdata_o, 32'h0);

    // Single fill
    req_wdata_i = {32'h0, 32'h0, 32'h1000_D0D0};
    req_valid_i = 3'b001;
    mem_ready_i = 1'b1;
    cycle();
    chk("fill_valid", mem_valid_o, 1'b1);
    chk("fill_data", mem_wdata_o, 32'h1000_D0D0);
    chk("fill_src", mem_src_o, 2'd0);
    req_valid_i = '0;
    cycle();
    chk("fill_drain", mem_valid_o, 1'b0);
    chk("fill_keep", mem_wdata_o, 32'h1000_D0D0);

    // Backpressure
    req_wdata_i = {32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    req_valid_i = 3'b111;
    cycle();
    hd = mem_wdata_o;
    hs = mem_src_o;
    mem_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_wdata_i = {$urandom, $urandom, $urandom};
      cycle();
      chk("bp_data", mem_wdata_o, hd);
      chk("bp_src", mem_src_o, hs);
      chk("bp_valid", mem_valid_o, 1'b1);
    end
    mem_ready_i = 1'b1;
    cycle();
    chk("bp_release", mem_wdata_o, req_wdata_i[W-1:0]);

    // Round-robin between 1 and 2
    do_reset();
    req_valid_i = 3'b110;
    mem_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("rr_src", mem_src_o, (k % 2 == 0) ? 2'd1 : 2'd2);
      chk("rr_valid", mem_valid_o, 1'b1);
    end
`ifdef DRAM_ARB_STAT_EN
    for (int s = 0; s < N; s++) begin
      stat_sel_i = IW'(s);
      #1;
      chk("stat_grant", stat_grant_o, (s == 0) ? 32'd0 : 32'd5);
      chk("stat_stall", stat_stall_o, 32'(m_stl[s]));
    end
`endif

    // Starvation override
    do_reset();
    req_valid_i = 3'b011;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("starve_src", mem_src_o, (k % 5 == 4) ? 2'd1 : 2'd0);
    end

    // Reset while holding
    do_reset();
    req_valid_i = 3'b111;
    cycle();
    mem_ready_i = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("rsth_valid", mem_valid_o, 1'b0);
    chk("rsth_src", mem_src_o, 2'd0);
    rst_n       = 1'b1;
    req_valid_i = 3'b110;
    mem_ready_i = 1'b1;
    cycle();
    chk("rsth_first", mem_src_o, 2'd1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      req_valid_i = N'($urandom_range(0, 7)) |
                    (($urandom % 2 == 0) ? 3'b011 : 3'b000);
      mem_ready_i = ($urandom % 4) != 0;
      req_wdata_i = {$urandom, $urandom, $urandom};
      rst_n       = ($urandom % 60) != 0;
      cycle();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
